mem_wb_stage_buf: RTL and testbench

- Next-generation MEM/WB pipeline stage register with a valid/ready handshake, so writeback can back-pressure the memory stage.
- Supports flush, and an optional skid slot that keeps in_ready registered so it breaks the combinational ready path.
- Masks writeback control on empty slots and provides wrapping performance counters.
- Sits between the data-memory stage and the register-file writeback logic.

---
 rtl/mem_wb_stage_buf.sv | 131 +++++++++++++
 tb/tb_mem_wb_stage_buf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_buf.sv
// MEM/WB stage register with valid/ready handshake, flush and optional skid slot; 1-cycle latency.
// Backpressure: SKID=0 in_ready = !out_valid | out_ready (comb); SKID=1 in_ready = !skid_valid (registered).
module mem_wb_stage_buf #(
  parameter int XLEN  = 32,
  parameter int WB_W  = 5,
  parameter int RD_W  = 5,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  inst_in,
  input  logic [XLEN-1:0]  aluout_in,
  input  logic [XLEN-1:0]  readdata_in,
  input  logic [WB_W-1:0]  wb_signal_in,
  input  logic [RD_W-1:0]  rd_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  inst_out,
  output logic [XLEN-1:0]  aluout_out,
  output logic [XLEN-1:0]  readdata_out,
  output logic [WB_W-1:0]  wb_signal_out,
  output logic [RD_W-1:0]  rd_out,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] aluout;
    logic [XLEN-1:0] readdata;
    logic [WB_W-1:0] wb;
    logic [RD_W-1:0] rd;
  } slot_t;

  slot_t in_dat;
  slot_t m_dat;
  logic  m_vld;
  logic  rdy_q;
  logic  accept;
  logic  retire;

  assign in_dat = {pc_in, inst_in, aluout_in, readdata_in, wb_signal_in, rd_in};
  assign accept = in_valid & in_ready;
  assign retire = m_vld & out_ready;

  generate
    if (SKID == 0) begin : g_single
      // rdy_q only holds in_ready low until the first edge after reset
      assign in_ready = rdy_q & (~m_vld | out_ready);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdy_q <= 1'b0;
          m_vld <= 1'b0;
          m_dat <= '0;
        end else begin
          rdy_q <= 1'b1;
          if (flush) begin
            m_vld <= 1'b0;
          end else if (accept) begin
            m_vld <= 1'b1;
            m_dat <= in_dat;
          end else if (retire) begin
            m_vld <= 1'b0;
          end
        end
      end
    end else begin : g_skid
      slot_t s_dat;
      logic  s_vld;

      assign in_ready = rdy_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdy_q <= 1'b0;
          m_vld <= 1'b0;
          m_dat <= '0;
          s_vld <= 1'b0;
          s_dat <= '0;
        end else if (flush) begin
          m_vld <= 1'b0;
          s_vld <= 1'b0;
          rdy_q <= 1'b1;
        end else if (m_vld & ~out_ready) begin
          // main slot held: a new arrival parks in the skid slot
          if (accept) begin
            s_vld <= 1'b1;
            s_dat <= in_dat;
            rdy_q <= 1'b0;
          end
        end else if (s_vld) begin
          // main retiring with skid full: promote skid, keeping order
          m_dat <= s_dat;
          s_vld <= 1'b0;
          rdy_q <= 1'b1;
        end else begin
          m_vld <= accept;
          if (accept) m_dat <= in_dat;
          rdy_q <= 1'b1;
        end
      end
    end
  endgenerate

  assign out_valid     = m_vld;
  assign pc_out        = m_dat.pc;
  assign inst_out      = m_dat.inst;
  assign aluout_out    = m_dat.aluout;
  assign readdata_out  = m_dat.readdata;
  assign wb_signal_out = m_vld ? m_dat.wb : '0;
  assign rd_out        = m_vld ? m_dat.rd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 1'b1;
      if (m_vld & ~out_ready) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Drives a skid (SKID=1) and a single-slot (SKID=0, CNT_W=4) instance with shared stimulus
// and compares both against a FIFO-occupancy reference model.
module tb_mem_wb_stage_buf;

  logic        clk;
  logic        rst;
  logic        in_valid, out_ready, flush;
  logic [31:0] pc_in, inst_in, aluout_in, readdata_in;
  logic [4:0]  wb_signal_in, rd_in;

  logic [1:0]       in_rdy, o_vld;
  logic [1:0][31:0] o_pc, o_inst, o_alu, o_rdat;
  logic [1:0][4:0]  o_wb, o_rd;
  logic [15:0]      rc1, sc1;
  logic [3:0]       rc0, sc0;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc, inst, alu, rdat;
    logic [4:0]  wb, rd;
  } item_t;

  // Reference model: per instance, an in-order queue with capacity 1 (SKID=0) or 2 (SKID=1)
  item_t mq [2][2];
  int    mcnt[2];
  int    mret[2];
  int    mstl[2];
  bit    up;
  bit    acc[2], ret[2], stl[2];

  mem_wb_stage_buf #(.XLEN(32), .WB_W(5), .RD_W(5), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .pc_in(pc_in), .inst_in(inst_in), .aluout_in(aluout_in), .readdata_in(readdata_in),
    .wb_signal_in(wb_signal_in), .rd_in(rd_in), .flush(flush),
    .out_valid(o_vld[1]), .out_ready(out_ready),
    .pc_out(o_pc[1]), .inst_out(o_inst[1]), .aluout_out(o_alu[1]), .readdata_out(o_rdat[1]),
    .wb_signal_out(o_wb[1]), .rd_out(o_rd[1]), .retire_cnt(rc1), .stall_cnt(sc1)
  );

  mem_wb_stage_buf #(.XLEN(32), .WB_W(5), .RD_W(5), .SKID(0), .CNT_W(4)) u_single (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .pc_in(pc_in), .inst_in(inst_in), .aluout_in(aluout_in), .readdata_in(readdata_in),
    .wb_signal_in(wb_signal_in), .rd_in(rd_in), .flush(flush),
    .out_valid(o_vld[0]), .out_ready(out_ready),
    .pc_out(o_pc[0]), .inst_out(o_inst[0]), .aluout_out(o_alu[0]), .readdata_out(o_rdat[0]),
    .wb_signal_out(o_wb[0]), .rd_out(o_rd[0]), .retire_cnt(rc0), .stall_cnt(sc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  function automatic logic [31:0] rcnt(input int m);
    return (m == 1) ? 32'(rc1) : 32'(rc0);
  endfunction

  function automatic logic [31:0] scnt(input int m);
    return (m == 1) ? 32'(sc1) : 32'(sc0);
  endfunction

  task automatic check_out();
    for (int m = 0; m < 2; m++) begin
      int wrap;
      wrap = (m == 1) ? 65536 : 16;
      chk("out_valid", m, 32'(o_vld[m]), 32'(mcnt[m] > 0));
      if (mcnt[m] > 0) begin
        chk("pc_out", m, o_pc[m], mq[m][0].pc);
        chk("inst_out", m, o_inst[m], mq[m][0].inst);
        chk("aluout_out", m, o_alu[m], mq[m][0].alu);
        chk("readdata_out", m, o_rdat[m], mq[m][0].rdat);
        chk("wb_signal_out", m, 32'(o_wb[m]), 32'(mq[m][0].wb));
        chk("rd_out", m, 32'(o_rd[m]), 32'(mq[m][0].rd));
      end else begin
        chk("wb_masked", m, 32'(o_wb[m]), 32'd0);
        chk("rd_masked", m, 32'(o_rd[m]), 32'd0);
      end
      chk("retire_cnt", m, rcnt(m), 32'(mret[m] % wrap));
      chk("stall_cnt", m, scnt(m), 32'(mstl[m] % wrap));
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready before the edge, outputs #1 after it
  task automatic step(input bit iv, input logic [31:0] pc, input logic [4:0] rd,
                      input bit ordy, input bit fl);
    item_t nw;
    bit    er;
    in_valid     = iv;
    pc_in        = pc;
    rd_in        = rd;
    inst_in      = $urandom;
    aluout_in    = $urandom;
    readdata_in  = $urandom;
    wb_signal_in = 5'($urandom_range(0, 31));
    out_ready    = ordy;
    flush        = fl;
    nw = '{pc: pc_in, inst: inst_in, alu: aluout_in, rdat: readdata_in, wb: wb_signal_in, rd: rd_in};
    #1;
    for (int m = 0; m < 2; m++) begin
      er = up && ((m == 1) ? (mcnt[m] < 2) : (mcnt[m] == 0 || ordy));
      chk("in_ready", m, 32'(in_rdy[m]), 32'(er));
      acc[m] = iv && er;
      ret[m] = (mcnt[m] > 0) && ordy;
      stl[m] = (mcnt[m] > 0) && !ordy;
    end
    @(posedge clk);
    up = 1'b1;
    for (int m = 0; m < 2; m++) begin
      if (ret[m]) mret[m]++;
      if (stl[m]) mstl[m]++;
      if (fl) begin
        mcnt[m] = 0;
      end else begin
        if (ret[m]) begin
          mq[m][0] = mq[m][1];
          mcnt[m]--;
        end
        if (acc[m]) begin
          mq[m][mcnt[m]] = nw;
          mcnt[m]++;
        end
      end
    end
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    up        = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0;
      mret[m] = 0;
      mstl[m] = 0;
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        chk("rst_in_ready", m, 32'(in_rdy[m]), 32'd0);
        chk("rst_out_valid", m, 32'(o_vld[m]), 32'd0);
        chk("rst_pc_out", m, o_pc[m], 32'd0);
        chk("rst_wb", m, 32'(o_wb[m]), 32'd0);
        chk("rst_rd", m, 32'(o_rd[m]), 32'd0);
        chk("rst_retire_cnt", m, rcnt(m), 32'd0);
        chk("rst_stall_cnt", m, scnt(m), 32'd0);
      end
    end
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) chk("release_in_ready", m, 32'(in_rdy[m]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    pc_in = '0; inst_in = '0; aluout_in = '0; readdata_in = '0;
    wb_signal_in = '0; rd_in = '0;

    // reset release, first idle cycle brings in_ready up
    do_reset();
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // streaming with out_ready=1
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 5'(i + 1), 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("stream_retire", 1, rcnt(1), 32'd4);
    chk("stream_stall", 1, scnt(1), 32'd0);

    // back-pressure fills main and skid slots
    step(1'b1, 32'h10, 5'd5, 1'b0, 1'b0);
    step(1'b1, 32'h14, 5'd6, 1'b0, 1'b0);
    step(1'b1, 32'h18, 5'd7, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("bp_pc_held", 1, o_pc[1], 32'h10);
    chk("bp_stall", 1, scnt(1), 32'd3);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("bp_second", 1, o_pc[1], 32'h14);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // flush with full buffer and a simultaneous offer
    step(1'b1, 32'h20, 5'd8, 1'b0, 1'b0);
    step(1'b1, 32'h24, 5'd9, 1'b0, 1'b0);
    step(1'b1, 32'h28, 5'd10, 1'b0, 1'b1);
    chk("flush_valid", 1, 32'(o_vld[1]), 32'd0);
    step(1'b1, 32'h2C, 5'd11, 1'b1, 1'b1);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // single-slot in_ready follows out_ready combinationally; no bubble on replace
    step(1'b1, 32'h30, 5'd12, 1'b0, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 32'h34, 5'd13, 1'b1, 1'b0);
    chk("nobubble_valid", 0, 32'(o_vld[0]), 32'd1);
    chk("nobubble_pc", 0, o_pc[0], 32'h34);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);

    // reset mid-traffic, then counter wrap on the 4-bit instance
    step(1'b1, 32'h40, 5'd1, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 32'(32'h100 + i * 4), 5'(i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("wrap_retire", 0, rcnt(0), 32'd1);
    chk("wide_retire", 1, rcnt(1), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
